alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, default 4, request FIFO depth in entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-006 req_op  input  4  ALU control code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 pass, 0101 and-reduce, 0110 or-reduce, 0111 shl, 1000 xor, 1001 shr.
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 alu_a, alu_b  output  8 each  operands driven to the external combinational ALU.
REQ-009 alu_ctrl  output  4  control code driven to the ALU.
REQ-010 alu_y  input  8  ALU result.
REQ-011 alu_ovf  input  1  ALU carry/borrow out.
REQ-012 alu_zero  input  1  ALU zero flag (result == 0).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  response consumed on an edge where rsp_valid && rsp_ready.
REQ-015 rsp_y  output  8;  rsp_ovf  output  1;  rsp_zero  output  1;  rsp_illegal  output  1  response payload.
REQ-016 count  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 FIFO SHALL store {op, a, b} in order; req_ready = (count < DEPTH); no push when full, even if a pop occurs that edge.
REQ-018 FSM SHALL have states IDLE (FIFO empty), EXEC (head valid, response slot free or draining this edge), and STALL (head valid, rsp_valid && !rsp_ready).
REQ-019 In EXEC, alu_a/alu_b/alu_ctrl SHALL equal the FIFO head; at the edge the head SHALL pop and alu_y/alu_ovf/alu_zero SHALL load into the response register, with rsp_valid=1.
REQ-020 Outside EXEC, alu_a, alu_b, and alu_ctrl SHALL be driven to 0.
REQ-021 Latency: for a request accepted at edge N into an empty FIFO with the response slot free, rsp_valid SHALL rise at edge N+1; throughput SHALL be one response per cycle while rsp_ready=1.
REQ-022 Codes 1010-1111 SHALL NOT be issued: during that EXEC cycle, alu outputs SHALL be 0 and the captured response SHALL be rsp_y=0, rsp_ovf=0, rsp_zero=1, rsp_illegal=1; otherwise rsp_illegal=0.
REQ-023 In STALL, response registers and FIFO head SHALL hold; when rsp_ready rises, the drain and the next EXEC capture SHALL occur on the same edge.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 Response payload SHALL remain stable while rsp_valid && !rsp_ready.

Reset
REQ-026 While reset_n=0 at an edge: FIFO SHALL empty, count=0, FSM=IDLE, rsp_valid=0, rsp_y=0, rsp_ovf=0, rsp_zero=0, rsp_illegal=0, and the sticky flag SHALL clear.
REQ-027 Reset during EXEC or STALL SHALL discard all pending requests and responses with no partial capture.
REQ-028 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro ALU_ISSUE_OVF_STICKY_EN, when defined, SHALL add ports ovf_sticky (output, 1) and ovf_clr (input, 1).
REQ-030 ovf_sticky SHALL set on any EXEC capture with alu_ovf=1 and clear on an edge with ovf_clr=1; set SHALL win when both occur on the same edge.
REQ-031 Without the macro, these ports and the sticky register SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-032 Push add a=F0 b=20 with rsp_ready=1 -> one edge later: rsp_y=10, rsp_ovf=1, rsp_zero=0.
REQ-033 Push sub a=05 b=05 -> rsp_y=00, rsp_ovf=0, rsp_zero=1; then sub 03-05 -> rsp_y=FE, rsp_ovf=1.
REQ-034 Hold rsp_ready=0 and push 6 requests with DEPTH=4 -> 5 accepted (1 in response register, 4 in FIFO), req_ready=0, count=4; release rsp_ready -> 5 responses in order on consecutive cycles.
REQ-035 Push op 1010 -> rsp_illegal=1, rsp_y=00, rsp_zero=1, and alu_ctrl=0 during its EXEC cycle.
REQ-036 Push 3 requests, then assert reset_n=0 for 1 cycle mid-STALL -> count=0, rsp_valid=0, and no stale response after release.
REQ-037 With the macro defined: add FF+01 -> ovf_sticky=1; then and-reduce -> ovf_sticky stays 1; ovf_clr pulse -> ovf_sticky=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: in-order request FIFO that issues {op, a, b} to an external combinational
// ALU and captures its result in a single registered response slot.
// Optional feature: define ALU_ISSUE_OVF_STICKY_EN to add ovf_sticky_o / ovf_clr_i.
module alu_issue #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [3:0]    req_op_i,
    input  logic [7:0]    req_a_i,
    input  logic [7:0]    req_b_i,
    output logic [7:0]    alu_a_o,
    output logic [7:0]    alu_b_o,
    output logic [3:0]    alu_ctrl_o,
    input  logic [7:0]    alu_y_i,
    input  logic          alu_ovf_i,
    input  logic          alu_zero_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [7:0]    rsp_y_o,
    output logic          rsp_ovf_o,
    output logic          rsp_zero_o,
    output logic          rsp_illegal_o,
`ifdef ALU_ISSUE_OVF_STICKY_EN
    output logic          ovf_sticky_o,
    input  logic          ovf_clr_i,
`endif
    output logic [AW:0]   count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, STALL} state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_y_q, rsp_y_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_ill_q, rsp_ill_d;
    logic [3:0]    head_op;
    logic [7:0]    head_a, head_b;
    logic          push, issue, illegal;

    assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];
    assign req_ready_o   = count_q < FULL;
    assign push          = req_valid_i && req_ready_o;
    assign count_o       = count_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_y_o       = rsp_y_q;
    assign rsp_ovf_o     = rsp_ovf_q;
    assign rsp_zero_o    = rsp_zero_q;
    assign rsp_illegal_o = rsp_ill_q;

    // Issue decision and next state: STALL with rsp_ready_i drains and re-issues on one edge
    always_comb begin
        issue       = (state_q == EXEC) || ((state_q == STALL) && rsp_ready_i);
        illegal     = head_op > 4'd9;
        alu_a_o     = (issue && !illegal) ? head_a : '0;
        alu_b_o     = (issue && !illegal) ? head_b : '0;
        alu_ctrl_o  = (issue && !illegal) ? head_op : '0;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = (push && !issue) ? count_q + (AW + 1)'(1) :
                      (!push && issue) ? count_q - (AW + 1)'(1) : count_q;
        rsp_valid_d = issue || (rsp_valid_q && !rsp_ready_i);
        rsp_y_d     = issue ? (illegal ? 8'h00 : alu_y_i) : rsp_y_q;
        rsp_ovf_d   = issue ? (!illegal && alu_ovf_i) : rsp_ovf_q;
        rsp_zero_d  = issue ? (illegal || alu_zero_i) : rsp_zero_q;
        rsp_ill_d   = issue ? illegal : rsp_ill_q;
        state_d     = (count_d == '0) ? IDLE : (rsp_valid_d ? STALL : EXEC);
    end

    // Pointers, occupancy, FSM and response slot; reset drops everything pending
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ill_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ill_q   <= rsp_ill_d;
        end
    end

    // FIFO storage; left unreset because occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {req_op_i, req_a_i, req_b_i};
    end

`ifdef ALU_ISSUE_OVF_STICKY_EN
    logic ovf_sticky_q;

    // Sticky overflow: any capture with carry/borrow sets it, ovf_clr_i clears it, set wins
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) ovf_sticky_q <= 1'b0;
        else ovf_sticky_q <= (issue && alu_ovf_i) || (ovf_sticky_q && !ovf_clr_i);
    end

    assign ovf_sticky_o = ovf_sticky_q;
`endif

endmodule
